// File: rtl/lut_prober.sv
// Probes a two-input logical unit through all four (a,b) combinations,
// rebuilds its truth-table word, names the gate and checks it against a reference.
module lut_prober #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected_func,
    input  logic       probe_out,
    output logic       probe_a,
    output logic       probe_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] func_rec,
    output logic [2:0] op_code,
    output logic       match
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned FUNC_W = 4;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_nxt;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FUNC_W-1:0]  shadow_q, shadow_d;
    logic [FUNC_W-1:0]  func_rec_d;
    logic [OP_W-1:0]    op_code_d;
    logic               match_d, busy_d, done_d, probe_a_d, probe_b_d;
    logic               sample_c, last_c;
    logic [FUNC_W-1:0]  word_c;

    // Truth-table word to gate class; anything unrecognised is 0
    function automatic logic [OP_W-1:0] classify(input logic [FUNC_W-1:0] w);
        case (w)
            4'b1000:          classify = OP_W'(1);
            4'b1110:          classify = OP_W'(2);
            4'b0110:          classify = OP_W'(3);
            4'b0111:          classify = OP_W'(4);
            4'b0001:          classify = OP_W'(5);
            4'b1001:          classify = OP_W'(6);
            4'b0000, 4'b1111: classify = OP_W'(7);
            default:          classify = OP_W'(0);
        endcase
    endfunction

    assign sample_c = (state_q == S_SETTLE) && (cnt_q == CNT_W'(SETTLE_CYCLES));
    assign last_c   = sample_c && (idx_q == IDX_W'(3));

    // Shadow word with the bit being sampled this edge merged in
    always_comb begin
        word_c        = shadow_q;
        word_c[idx_q] = probe_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            func_rec <= '0;
            op_code  <= '0;
            match    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            probe_a  <= 1'b0;
            probe_b  <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            func_rec <= func_rec_d;
            op_code  <= op_code_d;
            match    <= match_d;
            busy     <= busy_d;
            done     <= done_d;
            probe_a  <= probe_a_d;
            probe_b  <= probe_b_d;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (last_c) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values; probes follow the index being entered
    always_comb begin
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        func_rec_d = func_rec;
        op_code_d  = op_code;
        match_d    = match;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d    = '0;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            S_SETTLE: begin
                if (sample_c) begin
                    shadow_d = word_c;
                    cnt_d    = '0;
                    if (last_c) begin
                        func_rec_d = word_c;
                        op_code_d  = classify(word_c);
                        match_d    = (word_c == expected_func);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        busy_d    = (state_nxt == S_SETTLE);
        done_d    = (state_nxt == S_DONE);
        probe_a_d = (state_nxt == S_SETTLE) ? idx_d[1] : 1'b0;
        probe_b_d = (state_nxt == S_SETTLE) ? idx_d[0] : 1'b0;
    end

endmodule

// File: tb/tb_lut_prober.sv
// Bench for lut_prober: three instances (settle 1, 0, 3) each driving a modelled
// logical unit; table vectors, random runs and hand-built corner sequences.
module tb_lut_prober;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v, glitch_v, po_v, pa_v, pb_v, busy_v, done_v, match_v;
    logic [3:0] func_v [3];
    logic [3:0] exp_v  [3];
    logic [3:0] rec_v  [3];
    logic [2:0] op_v   [3];

    logic [3:0] prev_rec [3];
    logic [2:0] prev_op  [3];
    logic       prev_m   [3];

    int n_cmp = 0;
    int n_bad = 0;

    // Modelled unit under probe, with an optional forced-high glitch
    always_comb begin
        for (int i = 0; i < 3; i++)
            po_v[i] = glitch_v[i] | func_v[i][{pa_v[i], pb_v[i]}];
    end

    lut_prober #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .expected_func(exp_v[0]),
        .probe_out(po_v[0]), .probe_a(pa_v[0]), .probe_b(pb_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .func_rec(rec_v[0]), .op_code(op_v[0]), .match(match_v[0]));

    lut_prober #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[1]), .expected_func(exp_v[1]),
        .probe_out(po_v[1]), .probe_a(pa_v[1]), .probe_b(pb_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .func_rec(rec_v[1]), .op_code(op_v[1]), .match(match_v[1]));

    lut_prober #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[2]), .expected_func(exp_v[2]),
        .probe_out(po_v[2]), .probe_a(pa_v[2]), .probe_b(pb_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .func_rec(rec_v[2]), .op_code(op_v[2]), .match(match_v[2]));

    function automatic int settle_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    // Truth table of a named gate, bit i = gate(a=i[1], b=i[0])
    function automatic logic [3:0] gate_tt(input int g);
        logic [3:0] w;
        logic a, b;
        w = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a = i[1];
            b = i[0];
            case (g)
                1: w[i] = a & b;
                2: w[i] = a | b;
                3: w[i] = a ^ b;
                4: w[i] = ~(a & b);
                5: w[i] = ~(a | b);
                6: w[i] = ~(a ^ b);
                default: w[i] = 1'b0;
            endcase
        end
        return w;
    endfunction

    function automatic logic [2:0] classify(input logic [3:0] f);
        if (f == 4'h0 || f == 4'hF) return 3'd7;
        for (int g = 1; g <= 6; g++)
            if (gate_tt(g) == f) return 3'(g);
        return 3'd0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One full probe sequence on instance d; call at a negedge with the instance idle
    task automatic run(input int d, input logic [3:0] f, input logic [3:0] e, input bit glitch);
        int s, l, n;
        s = settle_of(d);
        l = 4 * (s + 1);
        func_v[d] = f;
        exp_v[d]  = e;
        start_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        n = 0;
        while (!done_v[d] && n < l + 20) begin
            if (n < l) begin
                chk("probe_ab", int'({pa_v[d], pb_v[d]}), n / (s + 1));
                chk("busy_run", int'(busy_v[d]), 1);
                chk("hold_rec", int'(rec_v[d]), int'(prev_rec[d]));
                chk("hold_match", int'(match_v[d]), int'(prev_m[d]));
                glitch_v[d] = glitch && (((n + 1) % (s + 1)) != 0);
            end
            @(negedge clk);
            n++;
        end
        glitch_v[d] = 1'b0;
        chk("latency", n, l);
        chk("func_rec", int'(rec_v[d]), int'(f));
        chk("op_code", int'(op_v[d]), int'(classify(f)));
        chk("match", int'(match_v[d]), int'(f == e));
        chk("busy_done", int'(busy_v[d]), 0);
        chk("probe_idle", int'({pa_v[d], pb_v[d]}), 0);
        prev_rec[d] = f;
        prev_op[d]  = classify(f);
        prev_m[d]   = (f == e);
        @(negedge clk);
        chk("done_pulse", int'(done_v[d]), 0);
    endtask

    typedef struct {
        logic [3:0] f;
        logic [3:0] e;
        logic [3:0] rec;
        logic [2:0] op;
        logic       m;
    } vec_t;

    vec_t tab [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, dc;
        logic [3:0] f, e;

        tab[0] = '{4'b1110, 4'b1110, 4'b1110, 3'd2, 1'b1};
        tab[1] = '{4'b0110, 4'b1000, 4'b0110, 3'd3, 1'b0};
        tab[2] = '{4'b1000, 4'b1000, 4'b1000, 3'd1, 1'b1};
        tab[3] = '{4'b1001, 4'b1001, 4'b1001, 3'd6, 1'b1};
        tab[4] = '{4'b0000, 4'b0000, 4'b0000, 3'd7, 1'b1};
        tab[5] = '{4'b1111, 4'b1111, 4'b1111, 3'd7, 1'b1};
        tab[6] = '{4'b0101, 4'b0101, 4'b0101, 3'd0, 1'b1};
        tab[7] = '{4'b0111, 4'b0111, 4'b0111, 3'd4, 1'b1};
        tab[8] = '{4'b0001, 4'b0011, 4'b0001, 3'd5, 1'b0};

        rst = 1'b0;
        start_v = '0;
        glitch_v = '0;
        for (int i = 0; i < 3; i++) begin
            func_v[i] = '0; exp_v[i] = '0;
            prev_rec[i] = '0; prev_op[i] = '0; prev_m[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_done", int'(done_v[0]), 0);
        chk("rst_probe", int'({pa_v[0], pb_v[0]}), 0);
        chk("rst_rec", int'(rec_v[0]), 0);
        chk("rst_op", int'(op_v[0]), 0);
        chk("rst_match", int'(match_v[0]), 0);
        rst = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            run(0, tab[i].f, tab[i].e, 1'b0);
            chk("tab_rec", int'(rec_v[0]), int'(tab[i].rec));
            chk("tab_op", int'(op_v[0]), int'(tab[i].op));
            chk("tab_match", int'(match_v[0]), int'(tab[i].m));
        end

        // Random words and references
        repeat (24) begin
            f = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 1) == 1) ? f : 4'($urandom_range(0, 15));
            run(0, f, e, 1'b0);
        end

        // All 16 words back-to-back with start held high
        func_v[0] = 4'h0;
        exp_v[0]  = 4'h0;
        start_v[0] = 1'b1;
        for (int fi = 0; fi < 16; fi++) begin
            n = 0;
            while (!done_v[0] && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("sweep_done_seen", int'(done_v[0]), 1);
            chk("sweep_rec", int'(rec_v[0]), fi);
            chk("sweep_op", int'(op_v[0]), int'(classify(4'(fi))));
            chk("sweep_match", int'(match_v[0]), 1);
            if (fi < 15) begin
                func_v[0] = 4'(fi + 1);
                exp_v[0]  = 4'(fi + 1);
            end else begin
                start_v[0] = 1'b0;
            end
            @(negedge clk);
            chk("sweep_idle_gap", int'(busy_v[0]), 0);
            chk("sweep_done_low", int'(done_v[0]), 0);
            if (fi < 15) begin
                @(negedge clk);
                chk("sweep_rebusy", int'(busy_v[0]), 1);
            end
        end
        prev_rec[0] = 4'hF; prev_op[0] = 3'd7; prev_m[0] = 1'b1;

        // Starts during SETTLE and during DONE are dropped
        func_v[0] = 4'b1110;
        exp_v[0]  = 4'b1110;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 3 || k == 6) start_v[0] = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
            if (done_v[0]) begin
                dc++;
                if (dc == 1) start_v[0] = 1'b1;
            end
        end
        chk("ignored_start_dones", dc, 1);
        chk("ignored_rec", int'(rec_v[0]), 4'b1110);
        chk("ignored_op", int'(op_v[0]), 2);
        chk("ignored_busy", int'(busy_v[0]), 0);
        prev_rec[0] = 4'b1110; prev_op[0] = 3'd2; prev_m[0] = 1'b1;

        // Asynchronous reset while idx=2
        func_v[0] = 4'b1001;
        exp_v[0]  = 4'b1001;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_idx", int'({pa_v[0], pb_v[0]}), 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", int'(busy_v[0]), 0);
        chk("arst_probe", int'({pa_v[0], pb_v[0]}), 0);
        chk("arst_rec", int'(rec_v[0]), 0);
        chk("arst_op", int'(op_v[0]), 0);
        chk("arst_match", int'(match_v[0]), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prev_rec[i] = '0; prev_op[i] = '0; prev_m[i] = 1'b0;
        end
        @(negedge clk);
        run(0, 4'b1001, 4'b1001, 1'b0);

        // Settle 0 and 3, with glitches on non-sample cycles
        run(1, 4'b0111, 4'b0111, 1'b1);
        chk("s0_op", int'(op_v[1]), 4);
        run(2, 4'b0111, 4'b0111, 1'b1);
        chk("s3_op", int'(op_v[2]), 4);
        run(2, 4'b0001, 4'b0001, 1'b1);
        run(1, 4'b1000, 4'b0110, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
